// File: rtl/outq_ctrl_if.sv
// CPU data-bus and downstream character-port signals of the output-queue controller.
// master = CPU/bus side, slave = the controller itself.
interface outq_ctrl_if;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  dwe;
   logic [31:0] drdata;
   logic [31:0] o_daddr;
   logic [31:0] o_dwdata;
   logic [3:0]  o_dwe;
   logic [31:0] o_drdata;

   modport master (
      output daddr, dwdata, dwe, o_drdata,
      input  drdata, o_daddr, o_dwdata, o_dwe
   );

   modport slave (
      input  daddr, dwdata, dwe, o_drdata,
      output drdata, o_daddr, o_dwdata, o_dwe
   );
endinterface

// File: rtl/outq_ctrl.sv
// Memory-mapped output queue: CPU stores fill a FIFO, a drain scheduler forwards
// one character at a time downstream with a programmable idle gap between forwards.
module outq_ctrl #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned DRAIN_GAP = 3,
   parameter logic [31:0] BASE_ADDR = 32'h0003_4570,
   parameter logic [31:0] OUT_ADDR  = 32'h0003_4560
) (
   input logic        clk,
   input logic        reset,
   outq_ctrl_if.slave bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned GAP_W = (DRAIN_GAP > 1) ? $clog2(DRAIN_GAP) : 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [GAP_W-1:0] GAP_LOAD = (DRAIN_GAP > 0) ? GAP_W'(DRAIN_GAP - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [15:0]        drops_q, drops_d;
   logic [31:0]        sent_q, sent_d;
   logic               enable_q, enable_d;
   logic [3:0]         o_dwe_q, o_dwe_d;
   logic [31:0]        o_dwdata_q, o_dwdata_d;
   logic [7:0]         mem_q [DEPTH];

   logic hit_data_c, hit_ctrl_c, hit_status_c, hit_sent_c;
   logic wr_c, push_req_c, push_c, pop_c, flush_c, drop_c, full_c, empty_c;
   logic unused_c;

   assign unused_c = ^{bus.o_drdata, bus.dwdata[31:8]};

   // Bus decode and FIFO accept/drop decisions
   always_comb begin
      hit_data_c   = (bus.daddr == BASE_ADDR);
      hit_ctrl_c   = (bus.daddr == BASE_ADDR + 32'd4);
      hit_status_c = (bus.daddr == BASE_ADDR + 32'd8);
      hit_sent_c   = (bus.daddr == BASE_ADDR + 32'd12);
      wr_c         = |bus.dwe;
      full_c       = (level_q == LVL_FULL);
      empty_c      = (level_q == '0);
      pop_c        = (state_q == ST_ISSUE) && !empty_c;
      flush_c      = wr_c && hit_ctrl_c && bus.dwdata[1];
      push_req_c   = wr_c && hit_data_c;
      // a full FIFO still accepts when the head leaves in the same cycle
      push_c       = push_req_c && !flush_c && (!full_c || pop_c);
      drop_c       = push_req_c && !flush_c && !push_c;
   end

   // Queue bookkeeping and counters
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      drops_d  = drops_q;
      sent_d   = sent_q;
      enable_d = enable_q;
      if (flush_c) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
      end
      if (drop_c && (drops_q != 16'hFFFF)) drops_d = drops_q + 16'd1;
      if (state_q == ST_ISSUE)             sent_d  = sent_q + 32'd1;
      if (wr_c && hit_ctrl_c)              enable_d = bus.dwdata[0];
   end

   // Drain scheduler next state; a flush in the deciding cycle suppresses the issue
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         ST_IDLE: begin
            if (enable_q && !empty_c && !flush_c) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (DRAIN_GAP > 0) begin
               state_d = ST_GAP;
               gap_d   = GAP_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_q == '0) state_d = ST_IDLE;
            else             gap_d   = gap_q - GAP_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Downstream outputs, registered so they line up with the ISSUE state
   always_comb begin
      o_dwe_d    = 4'b0000;
      o_dwdata_d = 32'd0;
      if (state_d == ST_ISSUE) begin
         o_dwe_d    = 4'b0001;
         o_dwdata_d = {24'd0, mem_q[rd_ptr_q]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         gap_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         drops_q    <= 16'd0;
         sent_q     <= 32'd0;
         enable_q   <= 1'b1;
         o_dwe_q    <= 4'b0000;
         o_dwdata_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         level_q    <= level_d;
         drops_q    <= drops_d;
         sent_q     <= sent_d;
         enable_q   <= enable_d;
         o_dwe_q    <= o_dwe_d;
         o_dwdata_q <= o_dwdata_d;
      end
   end

   // Storage has no reset; pointers and level define what is valid
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= bus.dwdata[7:0];
   end

   always_comb begin
      bus.drdata = 32'd0;
      if (hit_ctrl_c)        bus.drdata = {31'd0, enable_q};
      else if (hit_status_c) bus.drdata = {drops_q, full_c, empty_c, 6'd0, 8'(level_q)};
      else if (hit_sent_c)   bus.drdata = sent_q;
   end

   assign bus.o_daddr  = OUT_ADDR;
   assign bus.o_dwe    = o_dwe_q;
   assign bus.o_dwdata = o_dwdata_q;
endmodule

// File: tb/tb_outq_ctrl.sv
// Directed bench for outq_ctrl: reset values, drain timing, overflow, flush and reset.
module tb_outq_ctrl;
   localparam logic [31:0] BASE   = 32'h0003_4570;
   localparam logic [31:0] OUTA   = 32'h0003_4560;
   localparam logic [31:0] A_DATA = BASE;
   localparam logic [31:0] A_CTRL = BASE + 32'd4;
   localparam logic [31:0] A_STAT = BASE + 32'd8;
   localparam logic [31:0] A_SENT = BASE + 32'd12;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   int unsigned fw_cyc[$];
   logic [7:0]  fw_dat[$];

   outq_ctrl_if bus();

   outq_ctrl #(
      .DEPTH(16),
      .DRAIN_GAP(3),
      .BASE_ADDR(BASE),
      .OUT_ADDR(OUTA)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Log every forward seen downstream
   always @(negedge clk) begin
      if (bus.o_dwe != 4'b0000) begin
         fw_cyc.push_back(cyc);
         fw_dat.push_back(bus.o_dwdata[7:0]);
         check("fw_dwe", {28'd0, bus.o_dwe}, 32'h1);
         check("fw_addr", bus.o_daddr, OUTA);
      end
   end

   function automatic logic [31:0] fwd(input int i);
      if (i < fw_dat.size()) return {24'd0, fw_dat[i]};
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] fwc(input int i);
      if (i < fw_cyc.size()) return fw_cyc[i];
      return 32'hFFFF_FFFF;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
      bus.daddr  = addr;
      bus.dwdata = data;
      bus.dwe    = 4'hF;
      tick(1);
      bus.dwe    = 4'h0;
      bus.daddr  = 32'd0;
   endtask

   task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
      bus.daddr = addr;
      #1;
      data = bus.drdata;
      bus.daddr = 32'd0;
   endtask

   initial begin
      logic [31:0] rd;
      int unsigned t0;
      int base;

      bus.daddr    = 32'd0;
      bus.dwdata   = 32'd0;
      bus.dwe      = 4'h0;
      bus.o_drdata = 32'hDEAD_BEEF;
      tick(3);
      reset = 1'b0;
      tick(1);

      // reset state
      bus_rd(A_STAT, rd);      check("rst_status", rd, 32'h0000_4000);
      bus_rd(A_SENT, rd);      check("rst_sent", rd, 32'd0);
      bus_rd(A_CTRL, rd);      check("rst_ctrl", rd, 32'd1);
      bus_rd(A_DATA, rd);      check("rd_data_zero", rd, 32'd0);
      bus_rd(BASE + 32'h10, rd); check("rd_unmapped", rd, 32'd0);
      check("rst_o_dwe", {28'd0, bus.o_dwe}, 32'd0);
      check("rst_o_daddr", bus.o_daddr, OUTA);
      check("rst_o_dwdata", bus.o_dwdata, 32'd0);

      // 'H','i' back to back: first forward two edges later, second five after that
      t0 = cyc;
      bus_wr(A_DATA, 32'h48);
      bus_wr(A_DATA, 32'h69);
      tick(12);
      check("hi_count", fw_dat.size(), 32'd2);
      check("hi_d0", fwd(0), 32'h48);
      check("hi_c0", fwc(0), t0 + 2);
      check("hi_d1", fwd(1), 32'h69);
      check("hi_c1", fwc(1), t0 + 7);
      bus_rd(A_SENT, rd);      check("hi_sent", rd, 32'd2);
      bus_rd(A_STAT, rd);      check("hi_status", rd, 32'h0000_4000);

      // disabled overflow: 18 pushes into 16 entries
      base = fw_dat.size();
      bus_wr(A_CTRL, 32'd0);
      for (int i = 0; i < 18; i++) bus_wr(A_DATA, 32'h10 + i);
      tick(3);
      check("ovf_no_fwd", fw_dat.size(), base);
      bus_rd(A_STAT, rd);      check("ovf_status", rd, 32'h0002_8010);
      t0 = cyc;
      bus_wr(A_CTRL, 32'd1);
      tick(90);
      check("ovf_count", fw_dat.size(), base + 16);
      for (int k = 0; k < 16; k++) begin
         check("ovf_data", fwd(base + k), 32'h10 + k);
         check("ovf_cyc", fwc(base + k), t0 + 2 + 5 * k);
      end
      bus_rd(A_STAT, rd);      check("ovf_drained", rd, 32'h0002_4000);
      bus_rd(A_SENT, rd);      check("ovf_sent", rd, 32'd18);

      // full FIFO, push lands on the ISSUE cycle and is accepted
      base = fw_dat.size();
      bus_wr(A_CTRL, 32'd0);
      for (int i = 0; i < 16; i++) bus_wr(A_DATA, 32'h30 + i);
      t0 = cyc;
      bus_wr(A_CTRL, 32'd1);
      tick(1);
      bus_wr(A_DATA, 32'hA5);
      bus_rd(A_STAT, rd);      check("full_push_status", rd, 32'h0002_8010);
      tick(90);
      check("full_count", fw_dat.size(), base + 17);
      check("full_first", fwd(base), 32'h30);
      check("full_first_cyc", fwc(base), t0 + 2);
      check("full_last", fwd(base + 16), 32'hA5);
      bus_rd(A_SENT, rd);      check("full_sent", rd, 32'd35);
      bus_rd(A_STAT, rd);      check("full_status", rd, 32'h0002_4000);

      // flush while disabled: nothing forwarded afterwards
      base = fw_dat.size();
      bus_wr(A_CTRL, 32'd0);
      for (int i = 0; i < 5; i++) bus_wr(A_DATA, 32'h50 + i);
      bus_rd(A_STAT, rd);      check("fl_level5", rd, 32'h0002_0005);
      bus_wr(A_CTRL, 32'd3);
      bus_rd(A_STAT, rd);      check("fl_status", rd, 32'h0002_4000);
      bus_rd(A_CTRL, rd);      check("fl_ctrl", rd, 32'd1);
      tick(20);
      check("fl_no_fwd", fw_dat.size(), base);

      // flush on an ISSUE cycle: that forward completes, the rest is dropped
      t0 = cyc;
      bus_wr(A_DATA, 32'h77);
      bus_wr(A_DATA, 32'h78);
      bus_wr(A_CTRL, 32'd3);
      tick(20);
      check("fli_count", fw_dat.size(), base + 1);
      check("fli_data", fwd(base), 32'h77);
      check("fli_cyc", fwc(base), t0 + 2);
      bus_rd(A_SENT, rd);      check("fli_sent", rd, 32'd36);
      bus_rd(A_STAT, rd);      check("fli_status", rd, 32'h0002_4000);

      // reset while in GAP with four entries queued
      base = fw_dat.size();
      for (int i = 0; i < 5; i++) bus_wr(A_DATA, 32'h60 + i);
      bus_rd(A_STAT, rd);      check("gap_level4", rd, 32'h0002_0004);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("grst_o_dwe", {28'd0, bus.o_dwe}, 32'd0);
      bus_rd(A_STAT, rd);      check("grst_status", rd, 32'h0000_4000);
      bus_rd(A_SENT, rd);      check("grst_sent", rd, 32'd0);
      bus_rd(A_CTRL, rd);      check("grst_ctrl", rd, 32'd1);
      tick(15);
      check("grst_count", fw_dat.size(), base + 1);
      check("grst_data", fwd(base), 32'h60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
